// File: rtl/cond_pkg.sv
// Shared condition-code encodings and flag bit positions for the conditional-execution stage.
// Pure declarations: no logic, no latency, no flow control.
// Imported by cond_check, cond_unit and any later pipelined consumer.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] FLAGW_NZ = 2'b10;
    localparam logic [1:0] FLAGW_CV = 2'b01;

endpackage

// File: rtl/cond_check.sv
// Evaluates a 4-bit ARM condition field against {N,Z,C,V}.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the result with its own valid.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    always_comb begin
        n       = flags[FLAG_N];
        z       = flags[FLAG_Z];
        c       = flags[FLAG_C];
        v       = flags[FLAG_V];
        cond_ex = 1'b0;
        case (cond_e'(cond))
            EQ:      cond_ex = z;
            NE:      cond_ex = ~z;
            CS:      cond_ex = c;
            CC:      cond_ex = ~c;
            MI:      cond_ex = n;
            PL:      cond_ex = ~n;
            VS:      cond_ex = v;
            VC:      cond_ex = ~v;
            HI:      cond_ex = c & ~z;
            LS:      cond_ex = ~c | z;
            GE:      cond_ex = (n == v);
            LT:      cond_ex = (n != v);
            GT:      cond_ex = ~z & (n == v);
            LE:      cond_ex = z | (n != v);
            AL:      cond_ex = 1'b1;
            default: cond_ex = 1'b0; // NV is reserved and never executes
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Holds NZCV, evaluates the condition and gates write enables; COND_UNIT_STATS_EN adds exec/skip counters.
// Gated outputs are combinational from registered flags (zero latency); flags update on the next edge.
// No backpressure: one instruction per cycle, bubbles marked by valid=0.
module cond_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             no_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic             cond_ex,
    output logic [3:0]       flags
`ifdef COND_UNIT_STATS_EN
    ,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
`endif
);

    logic exec;

    // Uses only the registered flags: an instruction never sees its own ALU result.
    cond_check u_cond_check (
        .cond    (cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    assign exec      = valid & cond_ex;
    assign pc_src    = exec & pcs;
    assign reg_write = exec & reg_w & ~no_write;
    assign mem_write = exec & mem_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (exec) begin
            if ((flag_w & FLAGW_NZ) != 2'b00) begin
                flags[FLAG_N:FLAG_Z] <= alu_flags[FLAG_N:FLAG_Z];
            end
            if ((flag_w & FLAGW_CV) != 2'b00) begin
                flags[FLAG_C:FLAG_V] <= alu_flags[FLAG_C:FLAG_V];
            end
        end
    end

`ifdef COND_UNIT_STATS_EN
    // Counters hold at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_cnt <= '0;
            skip_cnt <= '0;
        end else if (valid) begin
            if (cond_ex) begin
                if (exec_cnt != '1) exec_cnt <= exec_cnt + CNT_W'(1);
            end else begin
                if (skip_cnt != '1) skip_cnt <= skip_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed plus randomized bench for cond_unit against a condition-code reference model.
module tb_cond_unit;

    localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_GT = 4'hC;
    localparam logic [3:0] C_AL = 4'hE, C_NV = 4'hF;
    localparam int TB_CNT_W = 2;
`ifdef COND_UNIT_STATS_EN
    localparam int CMAX = (1 << TB_CNT_W) - 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid = 1'b0;
    logic [3:0] cond = 4'h0;
    logic [3:0] alu_flags = 4'h0;
    logic [1:0] flag_w = 2'b00;
    logic       pcs = 1'b0, reg_w = 1'b0, mem_w = 1'b0, no_write = 1'b0;
    logic       pc_src, reg_write, mem_write, cond_ex;
    logic [3:0] flags;
`ifdef COND_UNIT_STATS_EN
    logic [TB_CNT_W-1:0] exec_cnt, skip_cnt;
`endif

    int         errors = 0;
    int         checks = 0;
    logic [3:0] m_flags = 4'h0;
    int         m_exec = 0, m_skip = 0;
    logic       ce;

    cond_unit #(.CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .cond      (cond),
        .alu_flags (alu_flags),
        .flag_w    (flag_w),
        .pcs       (pcs),
        .reg_w     (reg_w),
        .mem_w     (mem_w),
        .no_write  (no_write),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .mem_write (mem_write),
        .cond_ex   (cond_ex),
        .flags     (flags)
`ifdef COND_UNIT_STATS_EN
        ,
        .exec_cnt  (exec_cnt),
        .skip_cnt  (skip_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ARM rule: codes pair up as (test, inverse) on cond[0]; 1111 is reserved and never passes.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_flags"}, 32'(flags), 32'(m_flags));
`ifdef COND_UNIT_STATS_EN
        chk({tag, "_exec_cnt"}, 32'(exec_cnt), 32'(m_exec));
        chk({tag, "_skip_cnt"}, 32'(skip_cnt), 32'(m_skip));
`endif
    endtask

    // Reset is applied together with a flag-writing AL instruction: reset must win.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; valid = 1'b1; cond = C_AL; flag_w = 2'b11; alu_flags = 4'hF;
        @(posedge clk);
        #1;
        reset = 1'b0; valid = 1'b0;
        m_flags = 4'h0; m_exec = 0; m_skip = 0;
        check_state("reset");
    endtask

    task automatic apply(input logic v, input logic [3:0] c, input logic [3:0] af,
                         input logic [1:0] fw, input logic p, input logic r,
                         input logic m, input logic nw, output logic ce_o);
        logic exp_ce;
        @(negedge clk);
        valid = v; cond = c; alu_flags = af; flag_w = fw;
        pcs = p; reg_w = r; mem_w = m; no_write = nw;
        #1;
        exp_ce = ref_cond(c, m_flags);
        chk("cond_ex", 32'(cond_ex), 32'(exp_ce));
        chk("pc_src", 32'(pc_src), 32'(v && exp_ce && p));
        chk("reg_write", 32'(reg_write), 32'(v && exp_ce && r && !nw));
        chk("mem_write", 32'(mem_write), 32'(v && exp_ce && m));
        ce_o = cond_ex;
        @(posedge clk);
        if (v && exp_ce) begin
            if (fw[1]) m_flags[3:2] = af[3:2];
            if (fw[0]) m_flags[1:0] = af[1:0];
        end
`ifdef COND_UNIT_STATS_EN
        if (v && exp_ce && m_exec < CMAX) m_exec++;
        if (v && !exp_ce && m_skip < CMAX) m_skip++;
`endif
        #1;
        check_state("post_edge");
    endtask

    initial begin
        do_reset();

        // Flags 0000: EQ fails, NE passes.
        apply(1, C_EQ, 4'h0, 2'b00, 0, 1, 0, 0, ce);
        chk("eq_zero_flags", 32'(ce), 32'(0));
        apply(1, C_NE, 4'h0, 2'b00, 0, 1, 0, 0, ce);
        chk("ne_zero_flags", 32'(ce), 32'(1));

        // SUBS writes 0110, then EQ/CS pass and GT fails.
        apply(1, C_AL, 4'b0110, 2'b11, 0, 1, 0, 0, ce);
        chk("subs_flags", 32'(flags), 32'(4'b0110));
        apply(1, C_EQ, 4'h0, 2'b00, 0, 0, 0, 0, ce);
        chk("eq_after_subs", 32'(ce), 32'(1));
        apply(1, C_CS, 4'h0, 2'b00, 0, 0, 0, 0, ce);
        chk("cs_after_subs", 32'(ce), 32'(1));
        apply(1, C_GT, 4'h0, 2'b00, 0, 0, 0, 0, ce);
        chk("gt_after_subs", 32'(ce), 32'(0));

        // Partial writes touch only their bit group.
        apply(1, C_AL, 4'hF, 2'b11, 0, 0, 0, 0, ce);
        apply(1, C_AL, 4'h0, 2'b10, 0, 0, 0, 0, ce);
        chk("partial_nz", 32'(flags), 32'(4'b0011));
        apply(1, C_AL, 4'b1110, 2'b01, 0, 0, 0, 0, ce);
        chk("partial_cv", 32'(flags), 32'(4'b0010));

        // A failed condition must not update flags or enable writes.
        apply(1, C_AL, 4'h0, 2'b11, 0, 0, 0, 0, ce);
        apply(1, C_EQ, 4'b1001, 2'b11, 1, 1, 1, 0, ce);
        chk("failed_update_flags", 32'(flags), 32'(4'b0000));

        // CMP: flags update but no register write; a bubble changes nothing.
        apply(1, C_AL, 4'b0100, 2'b11, 0, 1, 0, 1, ce);
        chk("cmp_flags", 32'(flags), 32'(4'b0100));
        apply(0, C_AL, 4'hF, 2'b11, 1, 1, 1, 0, ce);
        chk("bubble_flags", 32'(flags), 32'(4'b0100));

        // Every condition against every flag value.
        for (int f = 0; f < 16; f++) begin
            apply(1, C_AL, 4'(f), 2'b11, 0, 0, 0, 0, ce);
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                valid = 1'b0; cond = 4'(c);
                #1;
                chk("exhaustive_cond_ex", 32'(cond_ex), 32'(ref_cond(4'(c), 4'(f))));
            end
        end
        apply(0, C_NV, 4'h0, 2'b00, 0, 0, 0, 0, ce);

`ifdef COND_UNIT_STATS_EN
        // Counters saturate, then clear on reset.
        do_reset();
        for (int i = 0; i < 5; i++) apply(1, C_AL, 4'h0, 2'b00, 0, 0, 0, 0, ce);
        chk("exec_saturated", 32'(exec_cnt), 32'(3));
        apply(1, C_NV, 4'h0, 2'b00, 0, 0, 0, 0, ce);
        chk("skip_one", 32'(skip_cnt), 32'(1));
        do_reset();
        chk("exec_after_reset", 32'(exec_cnt), 32'(0));
`endif

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                apply(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                      2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), ce);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Conditional-execution stage directly downstream of the ALU-with-flags block in the ARM core.
- Holds the architectural NZCV flag register, written from the ALU's n/z/c/v outputs.
- Evaluates the instruction's 4-bit condition field against the stored flags.
- Gates the decoder's PC/register/memory write enables so that failed-condition instructions become no-ops.

Parameters:
- CNT_W, 32, width of the statistics counters; only used when COND_UNIT_STATS_EN is defined.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- valid  in  1  the current instruction is real (not a bubble).
- cond  in  4  instruction condition field, bits [31:28].
- alu_flags  in  4  {n,z,c,v} from the ALU in the same cycle.
- flag_w  in  2  [1] update N,Z; [0] update C,V.
- pcs  in  1  decoder PC-write request.
- reg_w  in  1  decoder register-write request.
- mem_w  in  1  decoder memory-write request.
- no_write  in  1  suppress register write (CMP/CMN/TST/TEQ).
- pc_src  out  1  gated PC write.
- reg_write  out  1  gated register write.
- mem_write  out  1  gated memory write.
- cond_ex  out  1  condition passed.
- flags  out  4  current {N,Z,C,V} register.
- exec_cnt  out  CNT_W  (macro only) executed instructions.
- skip_cnt  out  CNT_W  (macro only) condition-failed instructions.

Behaviour:
- Reset (synchronous, active-high): flags=4'b0000; counters=0.
- cond_ex is combinational from the registered flags, zero added latency. It is independent of valid; all gated outputs include valid.
- Condition codes, with flags = {N,Z,C,V}:
  - 0000 EQ: Z.  0001 NE: ~Z.
  - 0010 CS: C.  0011 CC: ~C.
  - 0100 MI: N.  0101 PL: ~N.
  - 0110 VS: V.  0111 VC: ~V.
  - 1000 HI: C&~Z.  1001 LS: ~C|Z.
  - 1010 GE: N==V.  1011 LT: N!=V.
  - 1100 GT: ~Z&(N==V).  1101 LE: Z|(N!=V).
  - 1110 AL: 1.  1111: 0 (reserved, treated as never).
- Gated outputs (combinational):
  - pc_src = valid & cond_ex & pcs.
  - reg_write = valid & cond_ex & reg_w & ~no_write.
  - mem_write = valid & cond_ex & mem_w.
- Flag update on the clock edge, when valid & cond_ex:
  - flag_w[1]=1: flags[3:2] <= alu_flags[3:2].
  - flag_w[0]=1: flags[1:0] <= alu_flags[1:0].
  - Bit groups are independent; 2'b00 leaves flags unchanged.
- The condition evaluated in cycle t always uses the flags written at or before edge t-1. The instruction's own alu_flags never affect its own cond_ex (no bypass).
- Condition failed, or valid=0: no flag change, all gated outputs 0.
- reset asserted in the same cycle as a flag write: reset wins, flags=0.
- ALU logic ops report c=v=0. Decode must drive flag_w[0]=0 for them; this block does not inspect the opcode.

Optional Feature:
- Macro: COND_UNIT_STATS_EN.
- Defined:
  - exec_cnt/skip_cnt ports exist.
  - exec_cnt increments on valid & cond_ex; skip_cnt increments on valid & ~cond_ex.
  - Both saturate at all-ones and never wrap.
  - Both clear on reset.
- Undefined: ports and counters are absent; otherwise identical behaviour.

Decomposition:
- Package cond_pkg:
  - enum cond_e with the 16 codes (EQ..AL, NV).
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - localparam FLAGW_NZ=2'b10, FLAGW_CV=2'b01.
- Sub-module cond_check: purely combinational (cond, flags) -> cond_ex. Instantiated once here and reusable by a later pipelined core.

Test Plan:
- Reset, then cond=EQ, valid=1 with flags=0000 -> cond_ex=0, reg_write=0; cond=NE -> cond_ex=1.
- SUBS: cond=AL, flag_w=11, alu_flags=0110 -> next cycle flags=0110; EQ passes, CS passes, GT fails.
- Partial write: flags=1111, flag_w=10, alu_flags=0000 -> flags=0011; flag_w=01 leaves N,Z untouched.
- Failed update: flags=0000, cond=EQ, flag_w=11, alu_flags=1001 -> flags stay 0000, mem_write=0, pc_src=0.
- CMP: cond=AL, reg_w=1, no_write=1, flag_w=11 -> reg_write=0 and flags update; valid=0 bubble -> nothing changes.
- Exhaustive: all 16 cond × 16 flag values through cond_check vs. reference model, 1111 -> 0. With COND_UNIT_STATS_EN and CNT_W=2: 5 passes -> exec_cnt saturates at 3; reset mid-run -> counters and flags return to 0 at the next edge.
